uart_cmd_frame_parser: RTL and testbench

//  Framed command parser between uart_byte_rx (Rx_Done/data_byte) and the audio loopback control path.

---
 rtl/uart_cmd_frame_parser_if.sv | 8 +
 rtl/uart_cmd_frame_parser.sv | 179 +++++++++++++++++
 tb/tb_uart_cmd_frame_parser.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_frame_parser_if.sv
// rtl/uart_cmd_frame_parser_if.sv - received-byte strobe bundle from uart_byte_rx into the frame parser
interface uart_cmd_frame_parser_if;
    logic [7:0] rx_byte;
    logic       rx_valid;

    modport master (output rx_byte, output rx_valid);
    modport slave  (input  rx_byte, input  rx_valid);
endinterface

// File: rtl/uart_cmd_frame_parser.sv
// rtl/uart_cmd_frame_parser.sv - {HEADER,CMD,ARG,CHK} frame parser driving audio path enables and volume pulses
module uart_cmd_frame_parser #(
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 5000000,
    parameter logic [3:0]  MAX_VOL     = 4'd9
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_cmd_frame_parser_if.slave  rx,
    output logic                    echo_en,
    output logic                    nr_en,
    output logic                    effect_en,
    output logic                    vol_up,
    output logic                    vol_down,
    output logic                    vol_set,
    output logic [3:0]              vol_level,
    output logic                    frame_ok,
    output logic                    frame_err,
    output logic [7:0]              err_count
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_ARG  = 3'd2;
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_EXEC = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    arg_q, arg_d;
    logic          echo_q, echo_d;
    logic          nr_q, nr_d;
    logic          effect_q, effect_d;
    logic          vol_up_q, vol_up_d;
    logic          vol_down_q, vol_down_d;
    logic          vol_set_q, vol_set_d;
    logic [3:0]    vol_level_q, vol_level_d;
    logic          frame_ok_q, frame_err_q;
    logic [7:0]    err_count_q;
    logic          ok_fire, err_fire;
    logic [7:0]    chk_sum;
    logic [3:0]    clamp_lvl;

    assign chk_sum   = cmd_q + arg_q;
    assign clamp_lvl = (arg_q[7:4] != 4'd0)  ? MAX_VOL :
                       (arg_q[3:0] > MAX_VOL) ? MAX_VOL : arg_q[3:0];

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        echo_d      = echo_q;
        nr_d        = nr_q;
        effect_d    = effect_q;
        vol_level_d = vol_level_q;
        vol_up_d    = 1'b0;
        vol_down_d  = 1'b0;
        vol_set_d   = 1'b0;
        ok_fire     = 1'b0;
        err_fire    = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (rx.rx_valid && (rx.rx_byte == HEADER)) begin
                    state_d = S_CMD;
                end
            end
            S_CMD, S_ARG, S_CHK: begin
                // A byte arriving in the expiry cycle takes priority over the timeout.
                if (rx.rx_valid) begin
                    timer_d = '0;
                    case (state_q)
                        S_CMD: begin
                            cmd_d   = rx.rx_byte;
                            state_d = S_ARG;
                        end
                        S_ARG: begin
                            arg_d   = rx.rx_byte;
                            state_d = S_CHK;
                        end
                        default: begin
                            if (rx.rx_byte == chk_sum) begin
                                state_d = S_EXEC;
                            end else begin
                                err_fire = 1'b1;
                                state_d  = S_IDLE;
                            end
                        end
                    endcase
                end else if (timer_q == TIMER_MAX) begin
                    timer_d  = '0;
                    err_fire = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                timer_d = '0;
                ok_fire = 1'b1;
                case (cmd_q)
                    8'h01: echo_d   = ~echo_q;
                    8'h02: nr_d     = ~nr_q;
                    8'h03: effect_d = ~effect_q;
                    8'h10: {effect_d, nr_d, echo_d} = arg_q[2:0];
                    8'h0E: vol_up_d   = 1'b1;
                    8'h0F: vol_down_d = 1'b1;
                    8'h11: begin
                        vol_level_d = clamp_lvl;
                        vol_set_d   = 1'b1;
                    end
                    default: begin
                        ok_fire  = 1'b0;
                        err_fire = 1'b1;
                    end
                endcase
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            cmd_q       <= 8'h00;
            arg_q       <= 8'h00;
            echo_q      <= 1'b0;
            nr_q        <= 1'b0;
            effect_q    <= 1'b0;
            vol_up_q    <= 1'b0;
            vol_down_q  <= 1'b0;
            vol_set_q   <= 1'b0;
            vol_level_q <= 4'd0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            echo_q      <= echo_d;
            nr_q        <= nr_d;
            effect_q    <= effect_d;
            vol_up_q    <= vol_up_d;
            vol_down_q  <= vol_down_d;
            vol_set_q   <= vol_set_d;
            vol_level_q <= vol_level_d;
            frame_ok_q  <= ok_fire;
            frame_err_q <= err_fire;
            if (err_fire && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign echo_en   = echo_q;
    assign nr_en     = nr_q;
    assign effect_en = effect_q;
    assign vol_up    = vol_up_q;
    assign vol_down  = vol_down_q;
    assign vol_set   = vol_set_q;
    assign vol_level = vol_level_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_uart_cmd_frame_parser.sv
// tb/tb_uart_cmd_frame_parser.sv - table-driven and scoreboard bench for uart_cmd_frame_parser
module tb_uart_cmd_frame_parser;

    localparam int T = 40;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] arg;
        logic [7:0] chk;
        logic [2:0] lv;
        logic [3:0] lvl;
        logic [4:0] pl;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [4:0] pl;
        logic [2:0] lv;
        logic [3:0] lvl;
        logic [7:0] ecnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       echo_en, nr_en, effect_en, vol_up, vol_down, vol_set;
    logic       frame_ok, frame_err;
    logic [3:0] vol_level;
    logic [7:0] err_count;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    exp_t       sb[$];
    vec_t       tbl[17];
    logic [2:0] m_lv;
    logic [3:0] m_lvl;
    int         m_err;

    uart_cmd_frame_parser_if rx_if ();

    uart_cmd_frame_parser #(.HEADER(8'hA5), .TIMEOUT_CYC(T), .MAX_VOL(4'd9)) dut (
        .clk(clk), .reset(reset), .rx(rx_if),
        .echo_en(echo_en), .nr_en(nr_en), .effect_en(effect_en),
        .vol_up(vol_up), .vol_down(vol_down), .vol_set(vol_set),
        .vol_level(vol_level), .frame_ok(frame_ok), .frame_err(frame_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k,
                                input logic [2:0] lv, input logic [3:0] l, input logic [4:0] p);
        vec_t v;
        v.cmd = c; v.arg = a; v.chk = k; v.lv = lv; v.lvl = l; v.pl = p;
        return v;
    endfunction

    function automatic exp_t mk_exp(input logic [4:0] p);
        exp_t e;
        e.cyc  = 0;
        e.pl   = p;
        e.lv   = m_lv;
        e.lvl  = m_lvl;
        e.ecnt = 8'(m_err);
        return e;
    endfunction

    function automatic void bump_err();
        if (m_err < 255) m_err++;
    endfunction

    // pl = {frame_ok, frame_err, vol_up, vol_down, vol_set}; lv = {effect_en, nr_en, echo_en}
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_ok || frame_err) begin
                if (sb.size() == 0) begin
                    check("unexpected_frame_pulse", {frame_ok, frame_err}, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("latency", cyc, e.cyc);
                    check("pulses", {frame_ok, frame_err, vol_up, vol_down, vol_set}, e.pl);
                    check("levels", {effect_en, nr_en, echo_en}, e.lv);
                    check("vol_level", vol_level, e.lvl);
                    check("err_count", err_count, e.ecnt);
                end
            end else if (vol_up || vol_down || vol_set) begin
                check("stray_vol_pulse", {vol_up, vol_down, vol_set}, 0);
            end
        end
    end

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic push, input exp_t e,
                             input int lat, output int k);
        @(posedge clk);
        #1;
        k = cyc;
        if (push) begin
            e.cyc = k + lat;
            sb.push_back(e);
        end
        rx_if.rx_byte  = b;
        rx_if.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_if.rx_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_frame(input vec_t v);
        exp_t e;
        int   k;
        logic [7:0] s;
        s = v.cmd + v.arg;
        e = mk_exp(5'b0);
        send_byte(8'hA5, 1'b0, e, 0, k);
        send_byte(v.cmd, 1'b0, e, 0, k);
        send_byte(v.arg, 1'b0, e, 0, k);
        if (v.pl[3]) bump_err();
        m_lv  = v.lv;
        m_lvl = v.lvl;
        e = mk_exp(v.pl);
        send_byte(v.chk, 1'b1, e, (v.chk == s) ? 2 : 1, k);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_levels"}, {effect_en, nr_en, echo_en}, 0);
        check({tag, "_pulses"}, {frame_ok, frame_err, vol_up, vol_down, vol_set}, 0);
        check({tag, "_vol_level"}, vol_level, 0);
        check({tag, "_err_count"}, err_count, 0);
    endtask

    initial begin
        int   k;
        exp_t e;
        rx_if.rx_byte  = 8'h00;
        rx_if.rx_valid = 1'b0;
        m_lv = 3'b000; m_lvl = 4'd0; m_err = 0;

        tbl[0]  = mk(8'h01, 8'h00, 8'h01, 3'b001, 4'd0, 5'b10000);
        tbl[1]  = mk(8'h01, 8'h00, 8'h01, 3'b000, 4'd0, 5'b10000);
        tbl[2]  = mk(8'h10, 8'h05, 8'h15, 3'b101, 4'd0, 5'b10000);
        tbl[3]  = mk(8'h10, 8'hFD, 8'h0D, 3'b101, 4'd0, 5'b10000);
        tbl[4]  = mk(8'h11, 8'h0C, 8'h1D, 3'b101, 4'd9, 5'b10001);
        tbl[5]  = mk(8'h11, 8'h03, 8'h14, 3'b101, 4'd3, 5'b10001);
        tbl[6]  = mk(8'h0E, 8'h00, 8'hFF, 3'b101, 4'd3, 5'b01000);
        tbl[7]  = mk(8'h0E, 8'h00, 8'h0E, 3'b101, 4'd3, 5'b10100);
        tbl[8]  = mk(8'h0F, 8'h00, 8'h0F, 3'b101, 4'd3, 5'b10010);
        tbl[9]  = mk(8'h02, 8'h00, 8'h02, 3'b111, 4'd3, 5'b10000);
        tbl[10] = mk(8'h03, 8'h00, 8'h03, 3'b011, 4'd3, 5'b10000);
        tbl[11] = mk(8'h11, 8'h25, 8'h36, 3'b011, 4'd9, 5'b10001);
        tbl[12] = mk(8'h55, 8'h00, 8'h55, 3'b011, 4'd9, 5'b01000);
        tbl[13] = mk(8'h10, 8'h02, 8'h12, 3'b010, 4'd9, 5'b10000);
        tbl[14] = mk(8'h11, 8'h09, 8'h1A, 3'b010, 4'd9, 5'b10001);
        tbl[15] = mk(8'h11, 8'h0A, 8'h1B, 3'b010, 4'd9, 5'b10001);
        tbl[16] = mk(8'hA5, 8'h00, 8'hA5, 3'b010, 4'd9, 5'b01000);

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        send_byte(8'h37, 1'b0, e, 0, k);
        for (int i = 0; i < 17; i++) send_frame(tbl[i]);
        repeat (4) @(posedge clk);

        // Silence after CMD: error T cycles after the CMD byte; the late ARG/CHK bytes fall into IDLE.
        send_byte(8'hA5, 1'b0, e, 0, k);
        send_byte(8'h02, 1'b0, e, 0, k);
        bump_err();
        e = mk_exp(5'b01000);
        e.cyc = k + 1 + T;
        sb.push_back(e);
        wait_until(k + T);
        send_byte(8'h00, 1'b0, e, 0, k);
        send_byte(8'h02, 1'b0, e, 0, k);
        repeat (4) @(posedge clk);

        // ARG byte landing exactly in the expiry cycle still completes the frame.
        send_byte(8'hA5, 1'b0, e, 0, k);
        send_byte(8'h02, 1'b0, e, 0, k);
        wait_until(k + T - 1);
        send_byte(8'h00, 1'b0, e, 0, k);
        m_lv = m_lv ^ 3'b010;
        e = mk_exp(5'b10000);
        send_byte(8'h02, 1'b1, e, 2, k);
        repeat (4) @(posedge clk);

        for (int i = 0; i < 300; i++) begin
            logic [7:0] c;
            c = 8'(i);
            send_frame(mk(c, 8'h00, c + 8'h01, m_lv, m_lvl, 5'b01000));
        end
        repeat (4) @(posedge clk);
        check("err_count_saturated", err_count, 255);
        check("scoreboard_drained_1", sb.size(), 0);

        send_byte(8'hA5, 1'b0, e, 0, k);
        send_byte(8'h11, 1'b0, e, 0, k);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all_zero("midframe_reset");
        m_lv = 3'b000; m_lvl = 4'd0; m_err = 0;
        send_frame(mk(8'h01, 8'h00, 8'h01, 3'b001, 4'd0, 5'b10000));
        repeat (6) @(posedge clk);
        check("scoreboard_drained_2", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
